// File: rtl/matrix_add_stream.sv
// Streaming element-wise matrix adder: LANES lanes per beat, BEATS beats per matrix,
// two register stages with wrap/saturate arithmetic and a sticky per-matrix overflow flag.
module matrix_add_stream #(
    parameter int W      = 16,
    parameter int LANES  = 8,
    parameter int BEATS  = 8,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sat_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] a_data,
    input  logic [LANES*W-1:0] b_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic               out_last,
    output logic               out_ovf
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]      beat_cnt;
    logic               last_beat;
    logic               accept;
    logic               s1_adv;
    logic               s2_adv;

    logic               s1_valid;
    logic               s1_last;
    logic               s1_sat;
    logic [W:0]         s1_sum [LANES];
    logic [W:0]         raw_sum [LANES];

    logic               sticky;
    logic               beat_ovf;
    logic               lane_ovf;
    logic [W:0]         cur;
    logic [LANES*W-1:0] final_data;

    // Each stage may move whenever the stage after it has room or is being drained.
    assign s2_adv    = ~out_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign accept    = in_valid & s1_adv;
    assign last_beat = (beat_cnt == CW'(BEATS - 1));

    // Sums are one bit wider than the operands so stage 2 can judge overflow from the sum alone.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            if (SIGNED != 0) begin
                raw_sum[l] = {a_data[(LANES-1-l)*W + W-1], a_data[(LANES-1-l)*W +: W]}
                           + {b_data[(LANES-1-l)*W + W-1], b_data[(LANES-1-l)*W +: W]};
            end else begin
                raw_sum[l] = {1'b0, a_data[(LANES-1-l)*W +: W]}
                           + {1'b0, b_data[(LANES-1-l)*W +: W]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_sat   <= 1'b0;
            for (int l = 0; l < LANES; l++) s1_sum[l] <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_last <= last_beat;
                s1_sat  <= sat_mode;
                for (int l = 0; l < LANES; l++) s1_sum[l] <= raw_sum[l];
            end
        end
    end

    // Signed overflow shows as the two top bits of the widened sum disagreeing.
    always_comb begin
        beat_ovf   = 1'b0;
        lane_ovf   = 1'b0;
        cur        = '0;
        final_data = '0;
        for (int l = 0; l < LANES; l++) begin
            cur      = s1_sum[l];
            lane_ovf = (SIGNED != 0) ? (cur[W] ^ cur[W-1]) : cur[W];
            beat_ovf = beat_ovf | lane_ovf;
            if (lane_ovf & s1_sat) begin
                if (SIGNED != 0) begin
                    final_data[(LANES-1-l)*W +: W] = cur[W] ? {1'b1, {(W-1){1'b0}}}
                                                            : {1'b0, {(W-1){1'b1}}};
                end else begin
                    final_data[(LANES-1-l)*W +: W] = {W{1'b1}};
                end
            end else begin
                final_data[(LANES-1-l)*W +: W] = cur[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ovf   <= 1'b0;
            sticky    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= final_data;
                out_last <= s1_last;
                out_ovf  <= s1_last & (sticky | beat_ovf);
                sticky   <= s1_last ? 1'b0 : (sticky | beat_ovf);
            end
        end
    end

endmodule

// File: tb/tb_matrix_add_stream.sv
// Scoreboard bench for matrix_add_stream: default unsigned instance streamed under
// backpressure, plus small signed and 4-bit single-beat instances driven directly.
module tb_matrix_add_stream;

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic         d_sat = 1'b0, d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b1;
    logic [127:0] d_a = '0, d_b = '0, d_out_data;
    logic         d_out_last, d_out_ovf;

    logic         s_sat = 1'b0, s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_last, s_out_ovf;
    logic [47:0]  s_a = '0, s_b = '0, s_out_data;

    logic         t_sat = 1'b0, t_in_valid = 1'b0, t_in_ready, t_out_valid, t_out_last, t_out_ovf;
    logic [3:0]   t_a = '0, t_b = '0, t_out_data;

    exp_t         exp_q[$];
    logic [127:0] stim_a[$];
    logic [127:0] stim_b[$];
    logic         stim_sat[$];
    int           m_cnt = 0;
    bit           m_sticky = 0;
    int           accepted = 0;
    int           delivered = 0;

    always #5 clk = ~clk;

    matrix_add_stream dut (
        .clk(clk), .rst(rst), .sat_mode(d_sat), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a_data(d_a), .b_data(d_b), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .out_last(d_out_last), .out_ovf(d_out_ovf)
    );

    matrix_add_stream #(.W(16), .LANES(3), .BEATS(1), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .sat_mode(s_sat), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a_data(s_a), .b_data(s_b), .out_valid(s_out_valid), .out_ready(1'b1),
        .out_data(s_out_data), .out_last(s_out_last), .out_ovf(s_out_ovf)
    );

    matrix_add_stream #(.W(4), .LANES(1), .BEATS(1), .SIGNED(0)) dut_t (
        .clk(clk), .rst(rst), .sat_mode(t_sat), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .a_data(t_a), .b_data(t_b), .out_valid(t_out_valid), .out_ready(1'b1),
        .out_data(t_out_data), .out_last(t_out_last), .out_ovf(t_out_ovf)
    );

    // Reference lane arithmetic done on wide integers rather than on bit patterns.
    function automatic void model_lane(input int w, input bit sgn, input bit sat, input longint a,
                                       input longint b, output longint r, output bit ovf);
        longint modv, sa, sb, sum, hi, lo;
        modv = longint'(1) << w;
        if (sgn) begin
            sa  = (a >= modv / 2) ? a - modv : a;
            sb  = (b >= modv / 2) ? b - modv : b;
            sum = sa + sb;
            hi  = modv / 2 - 1;
            lo  = -(modv / 2);
            ovf = (sum > hi) || (sum < lo);
            if (ovf && sat) sum = (sum > 0) ? hi : lo;
        end else begin
            sum = a + b;
            ovf = (sum >= modv);
            if (ovf && sat) sum = modv - 1;
        end
        r = ((sum % modv) + modv) % modv;
    endfunction

    task automatic push_expected(input logic [127:0] a, input logic [127:0] b, input logic sat,
                                 input int cyc);
        exp_t   e;
        bit     any;
        bit     o;
        longint r;
        any    = 0;
        e.data = '0;
        for (int l = 0; l < 8; l++) begin
            model_lane(16, 0, sat, longint'(a[(7-l)*16 +: 16]), longint'(b[(7-l)*16 +: 16]), r, o);
            e.data[(7-l)*16 +: 16] = r[15:0];
            any = any | o;
        end
        e.last   = (m_cnt == 7);
        e.ovf    = e.last && (m_sticky || any);
        m_sticky = e.last ? 1'b0 : (m_sticky || any);
        m_cnt    = e.last ? 0 : m_cnt + 1;
        e.cyc    = cyc;
        exp_q.push_back(e);
    endtask

    // Streams the queued stimulus into the default instance and scores every delivered beat.
    task automatic run_stream(input int n, input bit rand_ready, input bit rand_gap,
                              input bit check_lat);
        int   sent = 0;
        int   cyc  = 0;
        exp_t e;
        bit   exp_ir;
        while ((sent < n || exp_q.size() != 0) && cyc < 2000) begin
            @(negedge clk);
            d_out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (sent < n && (!rand_gap || $urandom_range(0, 3) != 0)) begin
                d_in_valid = 1'b1;
                d_a        = stim_a[sent];
                d_b        = stim_b[sent];
                d_sat      = stim_sat[sent];
            end else begin
                d_in_valid = 1'b0;
            end
            #1;
            exp_ir = !((accepted - delivered) == 2 && !d_out_ready);
            total++;
            if (d_in_ready !== exp_ir) begin
                bad++;
                $display("[TB] FAIL in_ready cyc=%0d got=%b want=%b", cyc, d_in_ready, exp_ir);
            end
            if (d_out_valid && d_out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_beat got=%h want=none", d_out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (d_out_data !== e.data || d_out_last !== e.last || d_out_ovf !== e.ovf ||
                        (check_lat && (cyc - e.cyc) != 2)) begin
                        bad++;
                        $display("[TB] FAIL beat got=%h/last%b/ovf%b/lat%0d want=%h/last%b/ovf%b/lat2",
                                 d_out_data, d_out_last, d_out_ovf, cyc - e.cyc,
                                 e.data, e.last, e.ovf);
                    end
                end
                delivered++;
            end
            if (d_in_valid && d_in_ready) begin
                push_expected(d_a, d_b, d_sat, cyc);
                sent++;
                accepted++;
            end
            cyc++;
        end
        d_in_valid = 1'b0;
        if (cyc >= 2000) begin
            total++;
            bad++;
            $display("[TB] FAIL stream_timeout got=%0d want<2000", cyc);
        end
        stim_a.delete();
        stim_b.delete();
        stim_sat.delete();
    endtask

    function automatic logic [127:0] rand_lanes(input int maxv);
        logic [127:0] v;
        for (int l = 0; l < 8; l++) v[l*16 +: 16] = 16'($urandom_range(0, maxv));
        return v;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total += 5;
        if (d_out_valid !== 1'b0 || s_out_valid !== 1'b0 || t_out_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_valid got=%b%b%b want=000", d_out_valid, s_out_valid, t_out_valid);
        end
        if (d_out_data !== '0) begin
            bad++; $display("[TB] FAIL reset_data got=%h want=0", d_out_data);
        end
        if (d_out_last !== 1'b0 || d_out_ovf !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_flags got=%b%b want=00", d_out_last, d_out_ovf);
        end
        if (d_in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", d_in_ready);
        end
        rst = 1'b0;
        #1;
        if (d_in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL post_reset_in_ready got=%b want=1", d_in_ready);
        end
    endtask

    task automatic test_wrap;
        logic [127:0] a;
        logic [127:0] b;
        for (int i = 0; i < 8; i++) begin
            a = rand_lanes(16'h7FFF);
            b = rand_lanes(16'h7FFF);
            a[127:112] = 16'h0001; b[127:112] = 16'h0002;
            a[15:0]    = 16'hFFFF; b[15:0]    = 16'h0001;
            stim_a.push_back(a); stim_b.push_back(b); stim_sat.push_back(1'b0);
        end
        run_stream(8, 0, 0, 1);
        // A matrix with no overflowing lane must come out with the sticky flag cleared.
        for (int i = 0; i < 8; i++) begin
            stim_a.push_back(rand_lanes(16'h7FFF));
            stim_b.push_back(rand_lanes(16'h7FFF));
            stim_sat.push_back(1'b0);
        end
        run_stream(8, 0, 0, 1);
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 8; i++) begin
            stim_a.push_back({8{16'hFFF0}});
            stim_b.push_back({8{16'h0020}});
            stim_sat.push_back(1'b1);
        end
        run_stream(8, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            stim_a.push_back({$urandom, $urandom, $urandom, $urandom});
            stim_b.push_back({$urandom, $urandom, $urandom, $urandom});
            stim_sat.push_back(i[0]);
        end
        run_stream(8, 0, 1, 0);
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 16; i++) begin
            stim_a.push_back({$urandom, $urandom, $urandom, $urandom});
            stim_b.push_back(rand_lanes((i == 5) ? 16'hFFFF : 16'h3FFF));
            stim_sat.push_back(1'($urandom_range(0, 1)));
        end
        run_stream(16, 1, 1, 0);
    endtask

    task automatic test_reset_midmatrix;
        for (int i = 0; i < 3; i++) begin
            stim_a.push_back({8{16'h1234}});
            stim_b.push_back({8{16'hFFFF}});
            stim_sat.push_back(1'b0);
        end
        run_stream(3, 0, 0, 1);
        @(negedge clk);
        d_in_valid = 1'b1; d_a = {8{16'h4321}}; d_b = {8{16'hF000}}; d_sat = 1'b0; d_out_ready = 1'b1;
        @(negedge clk);
        d_in_valid = 1'b0;
        @(negedge clk);
        d_out_ready = 1'b0;
        #2;
        total++;
        if (d_out_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL inflight_before_reset got=%b want=1", d_out_valid);
        end
        rst = 1'b1;
        #1;
        total += 2;
        if (d_out_valid !== 1'b0 || d_out_last !== 1'b0 || d_out_ovf !== 1'b0) begin
            bad++; $display("[TB] FAIL async_reset_flags got=%b%b%b want=000", d_out_valid, d_out_last, d_out_ovf);
        end
        if (d_out_data !== '0 || d_in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL async_reset_data got=%h/rdy%b want=0/rdy1", d_out_data, d_in_ready);
        end
        exp_q.delete();
        m_cnt = 0; m_sticky = 0; accepted = 0; delivered = 0;
        @(negedge clk);
        rst = 1'b0;
        d_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            stim_a.push_back(rand_lanes(16'h7FFF));
            stim_b.push_back(rand_lanes(16'h7FFF));
            stim_sat.push_back(1'b0);
        end
        run_stream(8, 0, 0, 1);
    endtask

    task automatic test_signed;
        logic [47:0] va [3];
        logic [47:0] vb [3];
        logic        vs [3];
        logic [47:0] ve [3];
        logic        vo [3];
        va[0] = {16'h7FFF, 16'h8000, 16'h0005}; vb[0] = {16'h0001, 16'hFFFF, 16'hFFFE}; vs[0] = 1'b1;
        ve[0] = {16'h7FFF, 16'h8000, 16'h0003}; vo[0] = 1'b1;
        va[1] = va[0]; vb[1] = vb[0]; vs[1] = 1'b0;
        ve[1] = {16'h8000, 16'h7FFF, 16'h0003}; vo[1] = 1'b1;
        va[2] = {16'h0005, 16'hFFF0, 16'h0100}; vb[2] = {16'hFFFE, 16'h0010, 16'hFF00}; vs[2] = 1'b1;
        ve[2] = {16'h0003, 16'h0000, 16'h0000}; vo[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                total++;
                if (s_out_valid !== 1'b1 || s_out_data !== ve[i-2] || s_out_last !== 1'b1 ||
                    s_out_ovf !== vo[i-2]) begin
                    bad++;
                    $display("[TB] FAIL signed_%0d got=%h/v%b/last%b/ovf%b want=%h/v1/last1/ovf%b",
                             i - 2, s_out_data, s_out_valid, s_out_last, s_out_ovf, ve[i-2], vo[i-2]);
                end
            end
            s_in_valid = (i < 3);
            if (i < 3) begin
                s_a = va[i]; s_b = vb[i]; s_sat = vs[i];
            end
        end
        s_in_valid = 1'b0;
    endtask

    task automatic test_tiny;
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic       vs [3];
        logic [3:0] ve [3];
        logic       vo [3];
        va[0] = 4'hF; vb[0] = 4'h1; vs[0] = 1'b0; ve[0] = 4'h0; vo[0] = 1'b1;
        va[1] = 4'hF; vb[1] = 4'h1; vs[1] = 1'b1; ve[1] = 4'hF; vo[1] = 1'b1;
        va[2] = 4'h3; vb[2] = 4'h4; vs[2] = 1'b0; ve[2] = 4'h7; vo[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                total++;
                if (t_out_valid !== 1'b1 || t_out_data !== ve[i-2] || t_out_last !== 1'b1 ||
                    t_out_ovf !== vo[i-2]) begin
                    bad++;
                    $display("[TB] FAIL tiny_%0d got=%h/v%b/last%b/ovf%b want=%h/v1/last1/ovf%b",
                             i - 2, t_out_data, t_out_valid, t_out_last, t_out_ovf, ve[i-2], vo[i-2]);
                end
            end
            t_in_valid = (i < 3);
            if (i < 3) begin
                t_a = va[i]; t_b = vb[i]; t_sat = vs[i];
            end
        end
        t_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_backpressure();
        test_reset_midmatrix();
        test_signed();
        test_tiny();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
